// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: walks a feature map in PxP (stride P) windows and issues the reads.
//   It drives the external running-max register and hands each pooled pixel downstream.
// Ports:
//   clk, master_rst_n    clock, asynchronous active-low reset
//   start, abort         begin a pass (sampled in IDLE), return to IDLE from anywhere
//   base_addr            address of pixel (0,0), latched on an accepted start
//   rd_en, rd_addr       memory read strobe/address, data returns one cycle later
//   mr_ce, mr_rst_m      max register enable and clear
//   max_val              max register output
//   out_data, out_valid, out_ready   pooled pixel valid/ready port
//   busy, done           pass in progress, one-cycle end-of-pass pulse
module maxpool_ctrl #(
   parameter int N      = 16,
   parameter int ADDR_W = 12,
   parameter int P      = 2,
   parameter int IN_W   = 8,
   parameter int IN_H   = 8
) (
   input  logic              clk,
   input  logic              master_rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              mr_ce,
   output logic              mr_rst_m,
   input  logic [N-1:0]      max_val,
   output logic [N-1:0]      out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);
   localparam int OW = IN_W / P;
   localparam int OH = IN_H / P;
   localparam int CW = $clog2((IN_W > IN_H ? IN_W : IN_H) + 1) + 1;
   localparam logic [CW-1:0] P_L = CW'(P - 1);
   localparam logic [CW-1:0] OW_L = CW'(OW - 1);
   localparam logic [CW-1:0] OH_L = CW'(OH - 1);
   localparam logic [CW-1:0] ONE = CW'(1);
   typedef enum logic [2:0] {IDLE, CLEAR, READ, WAIT, OUT} state_t;
   state_t state, state_nx;
   logic [CW-1:0] wr, wc, i, j;
   logic [ADDR_W-1:0] base;
   logic ce_q, last_elem, last_win, hs;
   assign last_elem = (i == P_L) && (j == P_L);
   assign last_win = (wr == OH_L) && (wc == OW_L);
   assign hs = out_valid & out_ready;
   assign busy = state != IDLE;
   assign rd_en = state == READ;
   assign rd_addr = rd_en ? base + ADDR_W'((int'(wr) * P + int'(i)) * IN_W + int'(wc) * P + int'(j)) : '0;
   // Read data lands a cycle after rd_en, so the register enable trails it by one cycle.
   assign mr_ce = (state == CLEAR) | ce_q;
   assign mr_rst_m = state == CLEAR;
   assign out_valid = state == OUT;
   assign out_data = out_valid ? max_val : '0;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = start ? CLEAR : IDLE;
         CLEAR: state_nx = READ;
         READ:  state_nx = last_elem ? WAIT : READ;
         WAIT:  state_nx = OUT;
         OUT:   state_nx = out_ready ? (last_win ? IDLE : CLEAR) : OUT;
         default: state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
   end
   always_ff @(posedge clk or negedge master_rst_n) begin
      if (!master_rst_n) begin
         state <= IDLE;
         wr <= '0;
         wc <= '0;
         i <= '0;
         j <= '0;
         base <= '0;
         ce_q <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_nx;
         ce_q <= rd_en & ~abort;
         done <= hs & last_win & ~abort;
         if (state == IDLE && start && !abort) begin
            wr <= '0;
            wc <= '0;
            i <= '0;
            j <= '0;
            base <= base_addr;
         end
         // i and j both wrap to 0 after the last element, ready for the next window.
         if (state == READ) begin
            j <= (j == P_L) ? '0 : j + ONE;
            if (j == P_L) i <= (i == P_L) ? '0 : i + ONE;
         end
         if (hs) begin
            wc <= (wc == OW_L) ? '0 : wc + ONE;
            if (wc == OW_L) wr <= wr + ONE;
         end
      end
   end
endmodule
